// File: rtl/eth_tx_arbiter.sv
// Round-robin arbiter that moves one requester's packet at a time into the MAC
// TX buffer: data words first, then the packet length, then a send strobe.
module eth_tx_arbiter #(
  parameter int  num_req_p    = 4,
  parameter int  data_width_p = 32,
  parameter int  eth_mtu_p    = 2048,
  localparam int bpw_lp       = data_width_p / 8,
  localparam int size_w_lp    = $clog2(eth_mtu_p + 1),
  localparam int addr_w_lp    = $clog2(eth_mtu_p),
  localparam int osz_w_lp     = $clog2($clog2(bpw_lp) + 1),
  localparam int idx_w_lp     = $clog2(num_req_p)
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [num_req_p-1:0]              req_v_i,
  input  logic [num_req_p*size_w_lp-1:0]    req_size_i,
  input  logic [num_req_p*data_width_p-1:0] req_data_i,
  input  logic [num_req_p-1:0]              req_data_v_i,
  output logic [num_req_p-1:0]              req_data_yumi_o,
  output logic [num_req_p-1:0]              grant_o,
  output logic [num_req_p-1:0]              done_o,
  output logic [num_req_p-1:0]              reject_o,
  input  logic                              packet_req_i,
  output logic                              packet_wvalid_o,
  output logic [addr_w_lp-1:0]              packet_waddr_o,
  output logic [data_width_p-1:0]           packet_wdata_o,
  output logic [osz_w_lp-1:0]               packet_wdata_size_o,
  output logic                              packet_wsize_valid_o,
  output logic [size_w_lp-1:0]              packet_wsize_o,
  output logic                              packet_send_o
);

  localparam int words_shift_lp = $clog2(bpw_lp);

  typedef enum logic [2:0] {
    IDLE_S  = 3'd0,
    CHECK_S = 3'd1,
    DATA_S  = 3'd2,
    SIZE_S  = 3'd3,
    SEND_S  = 3'd4,
    DRAIN_S = 3'd5
  } state_e;

  function automatic logic [num_req_p-1:0] onehot_f(input logic [idx_w_lp-1:0] idx);
    onehot_f = {{(num_req_p-1){1'b0}}, 1'b1} << idx;
  endfunction

  state_e                 state_q, state_d;
  logic [idx_w_lp-1:0]    owner_q, owner_d;
  logic [idx_w_lp-1:0]    last_q, last_d;
  logic [size_w_lp-1:0]   size_q, size_d;
  logic [size_w_lp-1:0]   words_q, words_d;
  logic [addr_w_lp-1:0]   addr_q, addr_d;
  logic [size_w_lp-1:0]   wsize_q, wsize_d;
  logic                   wsize_valid_q, wsize_valid_d;
  logic                   send_q, send_d;
  logic [num_req_p-1:0]   grant_q, grant_d;
  logic [num_req_p-1:0]   done_q, done_d;
  logic [num_req_p-1:0]   reject_q, reject_d;

  logic [size_w_lp-1:0]    req_size_s [num_req_p];
  logic [data_width_p-1:0] req_data_s [num_req_p];
  logic                    win_found_s;
  logic [idx_w_lp-1:0]     win_idx_s;
  logic [idx_w_lp-1:0]     rr_idx_s;
  logic                    accept_s;
  logic                    size_illegal_s;
  logic [size_w_lp:0]      words_calc_s;

  // Split the flat per-requester buses into indexable arrays
  always_comb begin
    for (int i = 0; i < num_req_p; i++) begin
      req_size_s[i] = req_size_i[i*size_w_lp +: size_w_lp];
      req_data_s[i] = req_data_i[i*data_width_p +: data_width_p];
    end
  end

  // Round-robin search: walk from farthest to nearest so the nearest requester after last_q wins
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = {idx_w_lp{1'b0}};
    rr_idx_s    = {idx_w_lp{1'b0}};
    for (int i = num_req_p; i >= 1; i--) begin
      rr_idx_s    = idx_w_lp'((int'(last_q) + i) % num_req_p);
      win_found_s = win_found_s | req_v_i[rr_idx_s];
      win_idx_s   = req_v_i[rr_idx_s] ? rr_idx_s : win_idx_s;
    end
  end

  assign accept_s       = (state_q == DATA_S) && req_data_v_i[owner_q];
  assign size_illegal_s = (size_q == {size_w_lp{1'b0}}) || (size_q > size_w_lp'(eth_mtu_p));
  assign words_calc_s   = ({1'b0, size_q} + (size_w_lp+1)'(bpw_lp - 1)) >> words_shift_lp;

  // Next-state, latched transfer context and the registered strobes
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    size_d        = size_q;
    words_d       = words_q;
    addr_d        = addr_q;
    wsize_d       = wsize_q;
    wsize_valid_d = 1'b0;
    send_d        = 1'b0;
    done_d        = {num_req_p{1'b0}};
    reject_d      = {num_req_p{1'b0}};
    grant_d       = {num_req_p{1'b0}};
    case (state_q)
      IDLE_S: begin
        if (packet_req_i && win_found_s) begin
          owner_d = win_idx_s;
          size_d  = req_size_s[win_idx_s];
          state_d = CHECK_S;
        end else begin
          state_d = IDLE_S;
        end
      end
      CHECK_S: begin
        if (size_illegal_s) begin
          reject_d = onehot_f(owner_q);
          last_d   = owner_q;
          state_d  = IDLE_S;
        end else begin
          words_d = size_w_lp'(words_calc_s);
          addr_d  = {addr_w_lp{1'b0}};
          state_d = DATA_S;
        end
      end
      DATA_S: begin
        if (accept_s) begin
          addr_d  = addr_q + addr_w_lp'(bpw_lp);
          words_d = words_q - size_w_lp'(1);
          if (words_q == size_w_lp'(1)) begin
            wsize_valid_d = 1'b1;
            wsize_d       = size_q;
            state_d       = SIZE_S;
          end else begin
            state_d = DATA_S;
          end
        end else begin
          state_d = DATA_S;
        end
      end
      SIZE_S: begin
        send_d  = 1'b1;
        done_d  = onehot_f(owner_q);
        state_d = SEND_S;
      end
      SEND_S: begin
        last_d  = owner_q;
        state_d = DRAIN_S;
      end
      DRAIN_S: begin
        // Hold off re-arbitration until the MAC has visibly taken the buffer
        if (!packet_req_i) begin
          state_d = IDLE_S;
        end else begin
          state_d = DRAIN_S;
        end
      end
      default: begin
        state_d = IDLE_S;
      end
    endcase
    case (state_d)
      CHECK_S, DATA_S, SIZE_S, SEND_S: grant_d = onehot_f(owner_d);
      default:                         grant_d = {num_req_p{1'b0}};
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= IDLE_S;
      owner_q       <= {idx_w_lp{1'b0}};
      last_q        <= idx_w_lp'(num_req_p - 1);
      size_q        <= {size_w_lp{1'b0}};
      words_q       <= {size_w_lp{1'b0}};
      addr_q        <= {addr_w_lp{1'b0}};
      wsize_q       <= {size_w_lp{1'b0}};
      wsize_valid_q <= 1'b0;
      send_q        <= 1'b0;
      grant_q       <= {num_req_p{1'b0}};
      done_q        <= {num_req_p{1'b0}};
      reject_q      <= {num_req_p{1'b0}};
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      size_q        <= size_d;
      words_q       <= words_d;
      addr_q        <= addr_d;
      wsize_q       <= wsize_d;
      wsize_valid_q <= wsize_valid_d;
      send_q        <= send_d;
      grant_q       <= grant_d;
      done_q        <= done_d;
      reject_q      <= reject_d;
    end
  end

  assign req_data_yumi_o      = accept_s ? onehot_f(owner_q) : {num_req_p{1'b0}};
  assign packet_wvalid_o      = accept_s;
  assign packet_waddr_o       = addr_q;
  assign packet_wdata_o       = req_data_s[owner_q];
  assign packet_wdata_size_o  = osz_w_lp'(words_shift_lp);
  assign packet_wsize_valid_o = wsize_valid_q;
  assign packet_wsize_o       = wsize_q;
  assign packet_send_o        = send_q;
  assign grant_o              = grant_q;
  assign done_o               = done_q;
  assign reject_o             = reject_q;

endmodule
